// File: rtl/seg_display_mux_if.sv
// Display bus between the upstream clock logic and the multiplexed seven-segment driver.
interface seg_display_mux_if #(
  parameter int unsigned PWM_BITS = 8
);
  logic [15:0]         Digits;
  logic [3:0]          Dp;
  logic [PWM_BITS-1:0] Brightness;
  logic [3:0]          SegmentDrivers;
  logic [7:0]          SevenSegment;

  modport master (
    output Digits, Dp, Brightness,
    input  SegmentDrivers, SevenSegment
  );

  modport slave (
    input  Digits, Dp, Brightness,
    output SegmentDrivers, SevenSegment
  );
endinterface

// File: rtl/seg_display_mux.sv
// 4-digit time-multiplexed seven-segment driver with PWM dimming and frame-synchronous shadow capture.
// Optional LEADING_ZERO_BLANK_EN: digit 3 is dark when its shadowed code is 0.
module seg_display_mux #(
  parameter int unsigned REFRESH_DIV = 65536,
  parameter int unsigned PWM_BITS    = 8
) (
  input logic               Clk_100M,
  input logic               Reset,
  seg_display_mux_if.slave  bus
);
  localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [RW-1:0]       refresh_cnt_q, refresh_cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [15:0]         digits_sh_q, digits_sh_d;
  logic [3:0]          dp_sh_q, dp_sh_d;
  logic [3:0]          seg_drv_q, seg_drv_d;
  logic [7:0]          seven_seg_q, seven_seg_d;

  logic                term_c;
  logic [3:0]          cur_digit_c;
  logic                blank_c;

  // Active-low g..a glyph for a hex code.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    unique case (code)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Scan, PWM and shadow next-state plus registered pin values.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + RW'(1);
    idx_d         = idx_q;
    pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
    digits_sh_d   = digits_sh_q;
    dp_sh_d       = dp_sh_q;
    term_c        = (refresh_cnt_q == RW'(REFRESH_DIV - 1));

    if (term_c) begin
      refresh_cnt_d = '0;
      idx_d         = idx_q + 2'd1;
      // Load at frame end only, so a frame always shows one coherent value.
      if (idx_q == 2'd3) begin
        digits_sh_d = bus.Digits;
        dp_sh_d     = bus.Dp;
      end
    end

    cur_digit_c = digits_sh_q[{idx_q, 2'b00} +: 4];
    blank_c     = !((bus.Brightness == {PWM_BITS{1'b1}}) || (pwm_cnt_q < bus.Brightness));
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q == 2'd3) && (digits_sh_q[15:12] == 4'h0)) blank_c = 1'b1;
`endif

    if (blank_c) begin
      seg_drv_d   = 4'hF;
      seven_seg_d = 8'hFF;
    end else begin
      seg_drv_d   = ~(4'b0001 << idx_q);
      seven_seg_d = {~dp_sh_q[idx_q], glyph(cur_digit_c)};
    end
  end

  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      refresh_cnt_q <= '0;
      idx_q         <= '0;
      pwm_cnt_q     <= '0;
      digits_sh_q   <= '0;
      dp_sh_q       <= '0;
      seg_drv_q     <= 4'hF;
      seven_seg_q   <= 8'hFF;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      pwm_cnt_q     <= pwm_cnt_d;
      digits_sh_q   <= digits_sh_d;
      dp_sh_q       <= dp_sh_d;
      seg_drv_q     <= seg_drv_d;
      seven_seg_q   <= seven_seg_d;
    end
  end

  assign bus.SegmentDrivers = seg_drv_q;
  assign bus.SevenSegment   = seven_seg_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// Randomized bench for seg_display_mux against a cycle-count based display model (REFRESH_DIV=16).
module tb_seg_display_mux;
  localparam int unsigned D = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seg_display_mux_if #(.PWM_BITS(8)) bus ();

  seg_display_mux #(.REFRESH_DIV(D), .PWM_BITS(8)) dut (
    .Clk_100M (clk),
    .Reset    (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: everything derived from n = clock edges since reset release.
  int unsigned glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int unsigned n;
  int unsigned sh_dig;
  int unsigned sh_dp;
  logic [3:0]  exp_drv;
  logic [7:0]  exp_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; sh_dig = 0; sh_dp = 0;
      exp_drv = 4'hF; exp_seg = 8'hFF;
    end else begin
      int unsigned slot, ix, pw, dval, dpb;
      bit on;
      slot = n / D;
      ix   = slot % 4;
      pw   = n % 256;
      on   = (bus.Brightness == 8'hFF) || (pw < int'(bus.Brightness));
      dval = (sh_dig >> (4 * ix)) % 16;
      dpb  = (sh_dp >> ix) % 2;
`ifdef LEADING_ZERO_BLANK_EN
      if (ix == 3 && dval == 0) on = 1'b0;
`endif
      if (on) begin
        exp_drv = 4'(15 - (1 << ix));
        exp_seg = 8'(((dpb == 1) ? 0 : 128) + glyph_tab[dval]);
      end else begin
        exp_drv = 4'hF;
        exp_seg = 8'hFF;
      end
      if ((n % (4 * D)) == (4 * D - 1)) begin
        sh_dig = int'(bus.Digits);
        sh_dp  = int'(bus.Dp);
      end
      n++;
    end
  end

  // Per-cycle comparison against the model, plus the single-digit-select rule.
  always @(negedge clk) begin
    chk("drv", 32'(bus.SegmentDrivers), 32'(exp_drv));
    chk("seg", 32'(bus.SevenSegment), 32'(exp_seg));
    chk("one_low", 32'($countones(~bus.SegmentDrivers) <= 1), 32'd1);
  end

  task automatic count_on(input logic [7:0] b, input int want, input string tag);
    int cnt;
    cnt = 0;
    bus.Brightness = b;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (bus.SegmentDrivers != 4'hF) cnt++;
    end
    chk(tag, 32'(cnt), 32'(want));
  endtask

  initial begin
    int len;
    bit seen;
    checks = 0;
    errors = 0;
    bus.Digits = 16'h0; bus.Dp = 4'h0; bus.Brightness = 8'hFF;
    rst = 1'b0;
    #1 rst = 1'b1;

    repeat (5) @(negedge clk);
    chk("rst_drv", 32'(bus.SegmentDrivers), 32'hF);
    chk("rst_seg", 32'(bus.SevenSegment), 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_drv", 32'(bus.SegmentDrivers), 32'hE);
    chk("rel_seg", 32'(bus.SevenSegment), 32'hC0);

    // Frame 2 shows 1234 with DP on digit 2; mid-frame change lands in frame 3.
    bus.Digits = 16'h1234; bus.Dp = 4'b0100;
    repeat (84) @(negedge clk);
    bus.Digits = 16'h5678; bus.Dp = 4'b0000;
    repeat (110) @(negedge clk);

    count_on(8'h40, 64, "pwm_40");
    count_on(8'h00, 0, "pwm_00");
    count_on(8'hFF, 256, "pwm_ff");

    for (int i = 0; i < 40; i++) begin
      bus.Digits     = 16'($urandom);
      bus.Dp         = 4'($urandom);
      bus.Brightness = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      repeat ($urandom_range(1, 25)) @(negedge clk);
    end

    // Async reset in the middle of the digit-2 slot.
    bus.Brightness = 8'hFF; bus.Digits = 16'h1234; bus.Dp = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.SegmentDrivers == 4'hB) seen = 1'b1;
    end
    chk("find_slot2", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_drv", 32'(bus.SegmentDrivers), 32'hF);
    chk("async_seg", 32'(bus.SevenSegment), 32'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    len = 0;
    @(negedge clk);
    for (int i = 0; i < 40 && bus.SegmentDrivers == 4'hE; i++) begin
      len++;
      @(negedge clk);
    end
    chk("slot_len", 32'(len), 32'(D));
    chk("next_digit", 32'(bus.SegmentDrivers), 32'hD);

    // Leading-zero case; the model decides per build whether digit 3 is dark.
    bus.Digits = 16'h0930; bus.Dp = 4'h0;
    repeat (150) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
